// File: rtl/node_integrator_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : node_integrator_multi_if
//  Description : Control, current-input and node-output bundle for the
//                node integrator. The slave modport is the integrator side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface node_integrator_multi_if #(
   parameter int W        = 16,
   parameter int NCH      = 4,
   parameter int NIN      = 4,
   parameter int SETTLE_N = 8
);
   localparam int c_CW = $clog2(SETTLE_N + 1);

   logic                   en;
   logic                   clr;
   logic [NCH*NIN*W-1:0]   i_flat;
   logic [NCH*W-1:0]       v_flat;
   logic [NCH-1:0]         d;
   logic                   settled;
   logic [c_CW-1:0]        settle_cnt;

   modport master (
      output en, clr, i_flat,
      input  v_flat, d, settled, settle_cnt
   );

   modport slave (
      input  en, clr, i_flat,
      output v_flat, d, settled, settle_cnt
   );
endinterface
`default_nettype wire

// File: rtl/node_integrator_multi.sv
`default_nettype none
// ============================================================================
//  Module      : node_integrator_multi
//  Description : Clocked multi-node integrator. Each enabled cycle every node
//                voltage moves by (sum of its branch currents) >>> CSHIFT,
//                saturated to [VLO, VHI]. Per-node hysteresis digital level
//                and a global all-quiet settle detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module node_integrator_multi #(
   parameter int W        = 16,
   parameter int NCH      = 4,
   parameter int NIN      = 4,
   parameter int CSHIFT   = 2,
   parameter int VHI      = (1 << (W - 2)),
   parameter int VLO      = -(1 << (W - 2)),
   parameter int V_INIT   = VLO,
   parameter int HYST     = VHI / 16,
   parameter int TOL      = 0,
   parameter int SETTLE_N = 8
) (
   input  wire logic              eclk,
   input  wire logic              erst_n,
   node_integrator_multi_if.slave bus
);
   // Sum width is wide enough for NIN full-scale inputs; one more bit for v + dv.
   localparam int c_SW = W + $clog2(NIN);
   localparam int c_TW = c_SW + 1;
   localparam int c_CW = $clog2(SETTLE_N + 1);

   localparam logic signed [c_TW-1:0] c_VHI_T  = c_TW'(VHI);
   localparam logic signed [c_TW-1:0] c_VLO_T  = c_TW'(VLO);
   localparam logic signed [c_TW-1:0] c_TOL_T  = c_TW'(TOL);
   localparam logic signed [W-1:0]    c_VHI_W  = W'(VHI);
   localparam logic signed [W-1:0]    c_VLO_W  = W'(VLO);
   localparam logic signed [W-1:0]    c_VINIT  = W'(V_INIT);
   localparam logic signed [W-1:0]    c_HYST_P = W'(HYST);
   localparam logic signed [W-1:0]    c_HYST_N = W'(-HYST);
   localparam logic                   c_D_INIT = (V_INIT >= HYST);
   localparam logic [c_CW-1:0]        c_SN     = c_CW'(SETTLE_N);

   logic [NCH-1:0]  w_quiet;
   logic            w_all_quiet;
   logic [c_CW-1:0] r_cnt;

   genvar k;
   generate
      for (k = 0; k < NCH; k++) begin : g_node
         logic signed [c_SW-1:0] w_sum;
         logic signed [c_SW-1:0] w_dv;
         logic signed [c_TW-1:0] w_t;
         logic signed [W-1:0]    w_vn;
         logic signed [c_TW-1:0] w_diff;
         logic signed [c_TW-1:0] w_abs;
         logic                   w_dn;
         logic signed [W-1:0]    r_v;
         logic                   r_d;

         // Sign-extended sum of this node's branch currents.
         always_comb begin
            w_sum = '0;
            for (int j = 0; j < NIN; j++) begin
               w_sum = w_sum + c_SW'($signed(bus.i_flat[(k*NIN+j)*W +: W]));
            end
         end

         assign w_dv = w_sum >>> CSHIFT;
         assign w_t  = c_TW'(r_v) + c_TW'(w_dv);

         // Saturate the candidate voltage to the rails.
         always_comb begin
            if (w_t > c_VHI_T) begin
               w_vn = c_VHI_W;
            end else if (w_t < c_VLO_T) begin
               w_vn = c_VLO_W;
            end else begin
               w_vn = w_t[W-1:0];
            end
         end

         // Quiet is judged on the saturated change, so a rail-pinned node is quiet.
         assign w_diff     = c_TW'(w_vn) - c_TW'(r_v);
         assign w_abs      = w_diff[c_TW-1] ? -w_diff : w_diff;
         assign w_quiet[k] = (w_abs <= c_TOL_T);

         // Hysteresis decision taken on the new voltage so d tracks v_flat exactly.
         always_comb begin
            w_dn = r_d;
            if (w_vn >= c_HYST_P) begin
               w_dn = 1'b1;
            end else if (w_vn <= c_HYST_N) begin
               w_dn = 1'b0;
            end
         end

         // Node voltage and digital level registers.
         always_ff @(posedge eclk or negedge erst_n) begin
            if (!erst_n) begin
               r_v <= c_VINIT;
               r_d <= c_D_INIT;
            end else if (bus.clr) begin
               r_v <= c_VINIT;
               r_d <= c_D_INIT;
            end else if (bus.en) begin
               r_v <= w_vn;
               r_d <= w_dn;
            end
         end

         assign bus.v_flat[k*W +: W] = r_v;
         assign bus.d[k]             = r_d;
      end
   endgenerate

   assign w_all_quiet = &w_quiet;

   // Consecutive all-quiet run counter, saturating at SETTLE_N.
   always_ff @(posedge eclk or negedge erst_n) begin
      if (!erst_n) begin
         r_cnt <= '0;
      end else if (bus.clr) begin
         r_cnt <= '0;
      end else if (bus.en) begin
         if (!w_all_quiet) begin
            r_cnt <= '0;
         end else if (r_cnt != c_SN) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.settle_cnt = r_cnt;
   assign bus.settled    = (r_cnt == c_SN);
endmodule
`default_nettype wire
